// File: rtl/ex_operand_stage.sv
// ex_operand_stage: single-entry ID/EX register in front of the 64-bit ALU.
// Captures decoded operands, applies MEM/WB forwarding on accept, keeps
// snooping the forwarding buses while a held entry is stalled, and presents
// SrcA/SrcB/ALUCC to the ALU.
//
// Handshake: an upstream transfer happens on the rising edge where
// in_valid && in_ready; a downstream transfer happens on the rising edge where
// out_valid && out_ready. in_ready = !out_valid || out_ready, so a draining
// entry is replaced in the same cycle with no bubble. flush kills the held
// entry and any entry accepted in the same cycle; it does not affect in_ready.
module ex_operand_stage #(
  parameter int DATA_WIDTH     = 64,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic                      in_alu_src,
  input  logic [OPCODE_LENGTH-1:0]  in_alucc,
  input  logic                      fwd_mem_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_mem_rd,
  input  logic [DATA_WIDTH-1:0]     fwd_mem_data,
  input  logic                      fwd_wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_wb_rd,
  input  logic [DATA_WIDTH-1:0]     fwd_wb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  ALUCC,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic [DATA_WIDTH-1:0]     out_store_data
);

  // Held entry
  logic                      r_valid;
  logic [REG_ADDR_WIDTH-1:0] r_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] r_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0]     r_a;
  logic [DATA_WIDTH-1:0]     r_rs2_val;
  logic [DATA_WIDTH-1:0]     r_imm;
  logic                      r_alu_src;
  logic [OPCODE_LENGTH-1:0]  r_alucc;

  logic                      w_accept;
  logic                      w_stall;
  logic [REG_ADDR_WIDTH-1:0] w_a_addr;
  logic [REG_ADDR_WIDTH-1:0] w_b_addr;
  logic [DATA_WIDTH-1:0]     w_a_data;
  logic [DATA_WIDTH-1:0]     w_b_data;
  logic [DATA_WIDTH-1:0]     w_a_next;
  logic [DATA_WIDTH-1:0]     w_b_next;

  // Forwarding: x0 never forwards; MEM is younger than WB so it wins.
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0]     regdata,
    input logic                      mem_v,
    input logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input logic [DATA_WIDTH-1:0]     mem_d,
    input logic                      wb_v,
    input logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input logic [DATA_WIDTH-1:0]     wb_d
  );
    logic [DATA_WIDTH-1:0] res;
    res = regdata;
    if (addr != '0) begin
      if (mem_v && (mem_rd == addr))     res = mem_d;
      else if (wb_v && (wb_rd == addr))  res = wb_d;
    end
    return res;
  endfunction

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_stall  = r_valid && !out_ready;

  // Forwarding source: incoming operands on accept, held operands otherwise
  always_comb begin
    w_a_addr = r_rs1_addr;
    w_b_addr = r_rs2_addr;
    w_a_data = r_a;
    w_b_data = r_rs2_val;
    if (w_accept) begin
      w_a_addr = in_rs1_addr;
      w_b_addr = in_rs2_addr;
      w_a_data = in_rs1_data;
      w_b_data = in_rs2_data;
    end
    w_a_next = fwd(w_a_addr, w_a_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                   fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    w_b_next = fwd(w_b_addr, w_b_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                   fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
  end

  // Entry register: load on accept, snoop-repair operands while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_a        <= '0;
      r_rs2_val  <= '0;
      r_imm      <= '0;
      r_alu_src  <= 1'b0;
      r_alucc    <= '0;
    end else begin
      if (flush)               r_valid <= 1'b0;
      else if (w_accept)       r_valid <= 1'b1;
      else if (r_valid && out_ready) r_valid <= 1'b0;

      if (w_accept) begin
        r_rs1_addr <= in_rs1_addr;
        r_rs2_addr <= in_rs2_addr;
        r_rd_addr  <= in_rd_addr;
        r_a        <= w_a_next;
        r_rs2_val  <= w_b_next;
        r_imm      <= in_imm;
        r_alu_src  <= in_alu_src;
        r_alucc    <= in_alucc;
      end else if (w_stall) begin
        r_a        <= w_a_next;
        r_rs2_val  <= w_b_next;
      end
    end
  end

  assign out_valid      = r_valid;
  assign SrcA           = r_a;
  assign SrcB           = r_alu_src ? r_imm : r_rs2_val;
  assign ALUCC          = r_alucc;
  assign out_rd_addr    = r_rd_addr;
  assign out_store_data = r_rs2_val;

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Single-entry ID/EX pipeline register that sits directly upstream of the 64-bit ALU. It captures decoded operands, applies MEM/WB forwarding, and selects register or immediate for the second operand. It then presents `SrcA`, `SrcB` and `ALUCC` to the ALU under a valid/ready handshake. While a held entry is stalled, it keeps snooping forwarding buses so stale operands are repaired.

## Interface
- `DATA_WIDTH`, 64, operand width
- `OPCODE_LENGTH`, 4, ALU condition-code width
- `REG_ADDR_WIDTH`, 5, register index width

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; asynchronous, active-low; single clock domain
- `flush`  in  1  kill held entry and any entry being accepted this cycle
- `in_valid`  in  1  decode has an instruction
- `in_ready`  out  1  stage can accept
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr`  in  REG_ADDR_WIDTH  source/destination indices
- `in_rs1_data`, `in_rs2_data`  in  DATA_WIDTH  register-file read data
- `in_imm`  in  DATA_WIDTH  sign-extended immediate
- `in_alu_src`  in  1  1 = SrcB from immediate, 0 = from rs2
- `in_alucc`  in  OPCODE_LENGTH  ALU operation code
- `fwd_mem_valid`  in  1  MEM stage writes a register
- `fwd_mem_rd`  in  REG_ADDR_WIDTH  MEM destination
- `fwd_mem_data`  in  DATA_WIDTH  MEM result
- `fwd_wb_valid`, `fwd_wb_rd`, `fwd_wb_data`  in  1/REG_ADDR_WIDTH/DATA_WIDTH  same for WB
- `out_valid`  out  1  entry presented to ALU
- `out_ready`  in  1  downstream accepts
- `SrcA`, `SrcB`  out  DATA_WIDTH  ALU operands
- `ALUCC`  out  OPCODE_LENGTH  ALU operation code
- `out_rd_addr`  out  REG_ADDR_WIDTH  destination index
- `out_store_data`  out  DATA_WIDTH  forwarded rs2 value, independent of `in_alu_src`

## Operation
- Held state:
  - valid bit
  - rs1/rs2/rd addresses
  - A value and rs2 value
  - immediate
  - alu_src flag
  - alucc
- `SrcA` = held A. `SrcB` = held alu_src ? held imm : held rs2 value (combinational mux of registers). `out_store_data` = held rs2 value.
- `in_ready = !out_valid || out_ready`. A transfer happens on `in_valid && in_ready`.
- Forward function `fwd(addr, regdata)`:
  - if addr == 0, result is regdata.
  - else if `fwd_mem_valid` and `fwd_mem_rd` == addr, result is `fwd_mem_data`.
  - else if `fwd_wb_valid` and `fwd_wb_rd` == addr, result is `fwd_wb_data`.
  - else result is regdata.
  - MEM has priority over WB.
- Accept: the held fields load from inputs; A = fwd(rs1, in_rs1_data), rs2 value = fwd(rs2, in_rs2_data); valid ← 1.
- Stall (`out_valid && !out_ready`, no accept): A ← fwd(held rs1, held A) and rs2 value ← fwd(held rs2, held rs2 value). All other fields hold.
- Drain (`out_valid && out_ready && !in_valid`): valid ← 0. Data fields are don't-care but must not change.
- `flush`: valid ← 0 next edge, overriding any accept that cycle. `in_ready` is unaffected by flush.
- `ALUCC` passes through unchecked; undefined codes are the ALU's concern.

## Timing
- Reset (asynchronous assert, synchronous release on `clk`):
  - `out_valid`=0, `SrcA`=0, `SrcB`=0, `ALUCC`=0, `out_rd_addr`=0, `out_store_data`=0.
  - `in_ready`=1 during and after reset.
- Latency 1 cycle: an entry accepted at edge N has `out_valid`=1 after edge N.
- Throughput 1 per cycle with `out_ready` held high. Simultaneous drain and accept replaces the entry with no bubble.
- `out_valid` and all data outputs are register-driven. `SrcB` adds one mux level only. `in_ready` is combinational from `out_ready`.
- While `out_valid && !out_ready`, only the snoop repairs may change A and rs2 value. Every other output holds stable.
- Reset mid-stall discards the entry. No output glitches to nonzero during reset.

## Test plan
- Reset → `out_valid`=0, `in_ready`=1, all data outputs 0. Then accept rs1 data 5, rs2 data 7, alu_src=0, alucc=4'b0010, `out_ready`=1 → next cycle `SrcA`=5, `SrcB`=7, `ALUCC`=4'b0010, `out_valid`=1.
- Accept rs1=3, in_rs1_data=1, with MEM (rd 3, 0xAA) and WB (rd 3, 0xBB) both valid → `SrcA`=0xAA. Repeat with rs1=0 and both buses targeting rd 0 → `SrcA`=1.
- Accept alu_src=1, imm=0xFFFF_FFFF_FFFF_FFF0, rs2 data 9 → `SrcB`=0xFFFF_FFFF_FFFF_FFF0, `out_store_data`=9.
- Hold `out_ready`=0 with rs2=4 held, then pulse WB rd 4 data 0x55 → `out_store_data`=0x55. `in_ready`=0 throughout, and `SrcA`/`ALUCC` stay unchanged.
- Stream 4 entries back-to-back with `out_ready`=1 → 4 consecutive valid outputs in order, no bubbles.
- Assert `flush` together with an accept while valid → `out_valid`=0 next cycle. Assert `rst_n`=0 mid-stall → `out_valid` drops immediately and no transfer is observed.
